// File: rtl/isa_pnp_key_watcher.sv
// ISA PnP initiation-key watcher: synchronises IOW#/AEN, tracks the LFSR key
// written to the PnP address port and drives PnP configuration vs legacy mode.
module isa_pnp_key_watcher #(
  parameter int                ADDR_W           = 10,
  parameter logic [ADDR_W-1:0] KEY_PORT         = ADDR_W'(12'h279),
  parameter int                KEY_LEN          = 32,
  parameter logic [7:0]        LFSR_SEED        = 8'h6A,
  parameter bit                REQUIRE_PREAMBLE = 1'b1,
  parameter int                TIMEOUT_CYCLES   = 50000,
  parameter int                SYNC_STAGES      = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] isa_addr,
  input  logic [7:0]        isa_data,
  input  logic              isa_iow_n,
  input  logic              isa_aen,
  input  logic              sniffer_enable,
  input  logic              force_legacy,
  input  logic              return_to_wfk,
  output logic              key_detected,
  output logic              config_mode,
  output logic              legacy_mode,
  output logic [7:0]        match_count,
  output logic              key_abort
);

  typedef enum logic [2:0] {
    WAIT_KEY = 3'd0,
    PRE0     = 3'd1,
    ARMED    = 3'd2,
    MATCH    = 3'd3,
    CONFIG   = 3'd4
  } state_t;

  // The timer only has to reach TIMEOUT_CYCLES-1 before it saturates.
  localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TMO_LAST  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [7:0]      KEY_LEN_B = 8'(KEY_LEN);
  localparam bit              TMO_ON    = (TIMEOUT_CYCLES != 0);

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
    return {cur[1] ^ cur[0], cur[7:1]};
  endfunction

  state_t                 state;
  logic [7:0]             lfsr;
  logic [TW-1:0]          timer;
  logic [SYNC_STAGES-1:0] iow_sync;
  logic [SYNC_STAGES-1:0] aen_sync;
  logic                   iow_prev;
  logic                   write_event;
  logic                   force_exit;
  logic                   partial_key;
  logic                   timeout_hit;
  logic                   data_zero;
  logic                   data_seed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iow_sync <= '1;
      aen_sync <= '0;
      iow_prev <= 1'b1;
    end else begin
      iow_sync <= {iow_sync[SYNC_STAGES-2:0], isa_iow_n};
      aen_sync <= {aen_sync[SYNC_STAGES-2:0], isa_aen};
      iow_prev <= iow_sync[SYNC_STAGES-1];
    end
  end

  // Address and data are deliberately sampled raw; they are stable long before IOW# is seen low.
  assign write_event = iow_prev & ~iow_sync[SYNC_STAGES-1] & ~aen_sync[SYNC_STAGES-1]
                     & (isa_addr == KEY_PORT);
  assign force_exit  = force_legacy | ~sniffer_enable | return_to_wfk;
  assign partial_key = (state == PRE0) || (state == ARMED) || (state == MATCH);
  assign timeout_hit = TMO_ON && partial_key && (timer == TMO_LAST);
  assign data_zero   = (isa_data == 8'h00);
  assign data_seed   = (isa_data == LFSR_SEED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (write_event || (state == WAIT_KEY) || (state == CONFIG)) begin
      timer <= '0;
    end else if (timer != '1) begin
      timer <= timer + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_KEY;
      lfsr         <= LFSR_SEED;
      match_count  <= 8'd0;
      key_detected <= 1'b0;
      key_abort    <= 1'b0;
      config_mode  <= 1'b0;
      legacy_mode  <= 1'b1;
    end else begin
      key_detected <= 1'b0;
      key_abort    <= 1'b0;
      if (force_exit) begin
        state       <= WAIT_KEY;
        lfsr        <= LFSR_SEED;
        match_count <= 8'd0;
        key_abort   <= partial_key;
        config_mode <= 1'b0;
        legacy_mode <= 1'b1;
      end else if (write_event) begin
        case (state)
          WAIT_KEY: begin
            if (REQUIRE_PREAMBLE && data_zero) begin
              state <= PRE0;
            end else if (!REQUIRE_PREAMBLE && data_seed) begin
              state       <= MATCH;
              match_count <= 8'd1;
              lfsr        <= lfsr_step(LFSR_SEED);
            end
          end
          PRE0: begin
            if (data_zero) begin
              state <= ARMED;
              lfsr  <= LFSR_SEED;
            end else begin
              state <= WAIT_KEY;
            end
          end
          ARMED: begin
            if (data_seed) begin
              state       <= MATCH;
              match_count <= 8'd1;
              lfsr        <= lfsr_step(LFSR_SEED);
            end else if (!data_zero) begin
              state     <= WAIT_KEY;
              key_abort <= 1'b1;
            end
          end
          MATCH: begin
            if (isa_data == lfsr) begin
              match_count <= match_count + 8'd1;
              lfsr        <= lfsr_step(lfsr);
              if ((match_count + 8'd1) == KEY_LEN_B) begin
                state        <= CONFIG;
                key_detected <= 1'b1;
                config_mode  <= 1'b1;
                legacy_mode  <= 1'b0;
              end
            end else begin
              key_abort   <= 1'b1;
              match_count <= 8'd0;
              lfsr        <= LFSR_SEED;
              // A mismatching byte may itself be the start of a fresh attempt.
              if (REQUIRE_PREAMBLE && data_zero) begin
                state <= PRE0;
              end else if (!REQUIRE_PREAMBLE && data_seed) begin
                match_count <= 8'd1;
                lfsr        <= lfsr_step(LFSR_SEED);
              end else begin
                state <= WAIT_KEY;
              end
            end
          end
          CONFIG: begin
            state <= CONFIG;
          end
          default: begin
            state       <= WAIT_KEY;
            lfsr        <= LFSR_SEED;
            match_count <= 8'd0;
            config_mode <= 1'b0;
            legacy_mode <= 1'b1;
          end
        endcase
      end else if (timeout_hit) begin
        state       <= WAIT_KEY;
        lfsr        <= LFSR_SEED;
        match_count <= 8'd0;
        key_abort   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_isa_pnp_key_watcher.sv
// Bench for isa_pnp_key_watcher: a preamble/32-byte instance and a
// no-preamble/8-byte instance, checked against a key-table reference model.
module tb_isa_pnp_key_watcher;

  localparam int TMO_A = 300;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] addr;
  logic [7:0] data;
  logic       iow_n;
  logic       aen;
  logic [1:0] en, fl, rtw;
  logic [1:0] det, cfg, leg, ab;
  logic [7:0] cnt_o [2];

  int       vectors = 0;
  int       miscompares = 0;
  logic [7:0] key [32];
  int       ph [2];
  int       mc [2];
  bit       pre [2];
  int       klen [2];

  always #5 clk = ~clk;

  isa_pnp_key_watcher #(.TIMEOUT_CYCLES(TMO_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .isa_addr(addr), .isa_data(data),
    .isa_iow_n(iow_n), .isa_aen(aen), .sniffer_enable(en[0]),
    .force_legacy(fl[0]), .return_to_wfk(rtw[0]), .key_detected(det[0]),
    .config_mode(cfg[0]), .legacy_mode(leg[0]), .match_count(cnt_o[0]),
    .key_abort(ab[0]));

  isa_pnp_key_watcher #(.KEY_LEN(8), .REQUIRE_PREAMBLE(1'b0), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .isa_addr(addr), .isa_data(data),
    .isa_iow_n(iow_n), .isa_aen(aen), .sniffer_enable(en[1]),
    .force_legacy(fl[1]), .return_to_wfk(rtw[1]), .key_detected(det[1]),
    .config_mode(cfg[1]), .legacy_mode(leg[1]), .match_count(cnt_o[1]),
    .key_abort(ab[1]));

  // Model phases: 0 waiting, 1 one zero seen, 2 armed, 3 keying, 4 configured.
  function automatic void model_write(input int d, input logic [7:0] b,
                                      output bit de, output bit ae_o);
    de = 1'b0;
    ae_o = 1'b0;
    case (ph[d])
      0: if (pre[d] && b == 8'h00) ph[d] = 1;
         else if (!pre[d] && b == key[0]) begin ph[d] = 3; mc[d] = 1; end
      1: ph[d] = (b == 8'h00) ? 2 : 0;
      2: if (b == key[0]) begin ph[d] = 3; mc[d] = 1; end
         else if (b != 8'h00) begin ph[d] = 0; ae_o = 1'b1; end
      3: if (b == key[mc[d]]) begin
           mc[d]++;
           if (mc[d] == klen[d]) begin ph[d] = 4; de = 1'b1; end
         end else begin
           ae_o = 1'b1;
           mc[d] = 0;
           if (pre[d] && b == 8'h00) ph[d] = 1;
           else if (!pre[d] && b == key[0]) mc[d] = 1;
           else ph[d] = 0;
         end
      default: ;
    endcase
  endfunction

  function automatic bit model_force(input int d);
    bit was_partial;
    was_partial = (ph[d] >= 1) && (ph[d] <= 3);
    ph[d] = 0;
    mc[d] = 0;
    return was_partial;
  endfunction

  function automatic logic [7:0] next_good(input int d);
    if (ph[d] == 3) return key[mc[d]];
    if (ph[d] == 2 || !pre[d]) return key[0];
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input int d, input string tag, input bit de, input bit ae_o);
    check({tag, ".det"}, 32'(det[d]), 32'(de));
    check({tag, ".abort"}, 32'(ab[d]), 32'(ae_o));
    check({tag, ".count"}, 32'(cnt_o[d]), 32'(mc[d]));
    check({tag, ".config"}, 32'(cfg[d]), 32'(ph[d] == 4));
    check({tag, ".legacy"}, 32'(leg[d]), 32'(ph[d] != 4));
  endtask

  // One complete IOW# cycle; outputs are sampled where the write's effect lands.
  task automatic wr(input int d, input logic [9:0] a, input logic [7:0] b,
                    input logic ae_in, input string tag);
    bit de, ae_o;
    de = 1'b0;
    ae_o = 1'b0;
    if (a == 10'h279 && !ae_in && en[d] && !fl[d]) model_write(d, b, de, ae_o);
    @(negedge clk);
    addr = a; data = b; aen = ae_in; iow_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs(d, tag, de, ae_o);
    @(negedge clk);
    iow_n = 1'b1; aen = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic pulse_rtw(input int d, input string tag);
    bit ae_o;
    @(negedge clk);
    rtw[d] = 1'b1;
    ae_o = model_force(d);
    @(posedge clk);
    #1 check_outputs(d, tag, 1'b0, ae_o);
    @(negedge clk);
    rtw[d] = 1'b0;
  endtask

  task automatic set_ctrl(input int d, input bit is_force, input logic v, input string tag);
    bit ae_o;
    ae_o = 1'b0;
    @(negedge clk);
    if (is_force) fl[d] = v; else en[d] = v;
    if (fl[d] || !en[d]) ae_o = model_force(d);
    @(posedge clk);
    #1 check_outputs(d, tag, 1'b0, ae_o);
  endtask

  task automatic write_key(input int d, input int from, input int upto, input string tag);
    for (int i = from; i < upto; i++) wr(d, 10'h279, key[i], 1'b0, $sformatf("%s%0d", tag, i));
  endtask

  task automatic random_writes(input int d, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (ph[d] == 4 && r < 5) pulse_rtw(d, $sformatf("%s_rtw%0d", tag, i));
      else if (r == 0) wr(d, 10'h279, 8'h00, 1'b0, $sformatf("%s_z%0d", tag, i));
      else if (r == 1) wr(d, 10'h279, 8'($urandom), 1'b0, $sformatf("%s_r%0d", tag, i));
      else if (r == 2) wr(d, 10'h279, next_good(d), 1'b1, $sformatf("%s_aen%0d", tag, i));
      else if (r == 3) wr(d, 10'h27A, next_good(d), 1'b0, $sformatf("%s_adr%0d", tag, i));
      else wr(d, 10'h279, next_good(d), 1'b0, $sformatf("%s_k%0d", tag, i));
    end
  endtask

  initial begin
    int first_k;
    key[0] = 8'h6A;
    for (int i = 1; i < 32; i++) begin
      int v;
      v = int'(key[i-1]);
      key[i] = 8'((v >> 1) | (((v ^ (v >> 1)) & 1) << 7));
    end
    pre[0] = 1'b1; klen[0] = 32; pre[1] = 1'b0; klen[1] = 8;
    ph[0] = 0; ph[1] = 0; mc[0] = 0; mc[1] = 0;
    rst_n = 1'b0; addr = '0; data = '0; iow_n = 1'b1; aen = 1'b0;
    en = 2'b01; fl = 2'b00; rtw = 2'b00;
    repeat (3) @(posedge clk);
    #1 check_outputs(0, "rst_a", 1'b0, 1'b0);
    check_outputs(1, "rst_b", 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Full key with preamble, then leave via return_to_wfk.
    wr(0, 10'h279, 8'h00, 1'b0, "pre0");
    wr(0, 10'h279, 8'h00, 1'b0, "pre1");
    write_key(0, 0, 32, "key");
    wr(0, 10'h279, key[0], 1'b0, "cfg_ignored");
    pulse_rtw(0, "rtw");

    // Byte 10 corrupted, then a full retry.
    wr(0, 10'h279, 8'h00, 1'b0, "bad_pre0");
    wr(0, 10'h279, 8'h00, 1'b0, "bad_pre1");
    write_key(0, 0, 9, "bad_key");
    wr(0, 10'h279, 8'h55, 1'b0, "bad_byte10");
    wr(0, 10'h279, 8'h00, 1'b0, "retry_pre0");
    wr(0, 10'h279, 8'h00, 1'b0, "retry_pre1");
    write_key(0, 0, 32, "retry_key");
    set_ctrl(0, 1'b0, 1'b0, "disable_in_cfg");
    set_ctrl(0, 1'b0, 1'b1, "reenable");

    // Inter-byte timeout: abort exactly TMO_A cycles after the last write lands.
    wr(0, 10'h279, 8'h00, 1'b0, "tmo_pre0");
    wr(0, 10'h279, 8'h00, 1'b0, "tmo_pre1");
    write_key(0, 0, 2, "tmo_key");
    first_k = 0;
    for (int k = 4; k <= TMO_A + 3; k++) begin
      @(posedge clk);
      #1 if (ab[0] && first_k == 0) first_k = k;
    end
    check("timeout_cycle", 32'(first_k), 32'(TMO_A));
    void'(model_force(0));
    wr(0, 10'h279, key[1], 1'b0, "after_tmo_b5");

    // Writes with AEN high or to the wrong port are invisible.
    wr(0, 10'h279, 8'h00, 1'b1, "aen_pre0");
    wr(0, 10'h279, 8'h00, 1'b1, "aen_pre1");
    write_key(0, 0, 32, "aen_key");
    wr(0, 10'h27A, 8'h00, 1'b0, "port_pre0");
    wr(0, 10'h27A, 8'h00, 1'b0, "port_pre1");
    write_key(0, 0, 32, "port_key");
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); addr = 10'h27A; data = key[i]; iow_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); iow_n = 1'b1;
      repeat (3) @(posedge clk);
    end
    #1 check_outputs(0, "port_final", 1'b0, 1'b0);

    // force_legacy held from byte 20 onward: abort and no detection.
    wr(0, 10'h279, 8'h00, 1'b0, "fl_pre0");
    wr(0, 10'h279, 8'h00, 1'b0, "fl_pre1");
    write_key(0, 0, 19, "fl_key");
    set_ctrl(0, 1'b1, 1'b1, "force_on");
    write_key(0, 19, 32, "fl_held");
    set_ctrl(0, 1'b1, 1'b0, "force_off");

    // Asynchronous reset in the middle of a key.
    wr(0, 10'h279, 8'h00, 1'b0, "ar_pre0");
    wr(0, 10'h279, 8'h00, 1'b0, "ar_pre1");
    write_key(0, 0, 3, "ar_key");
    @(negedge clk);
    #2 rst_n = 1'b0;
    ph[0] = 0; mc[0] = 0;
    #1 check_outputs(0, "async_rst", 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    random_writes(0, 80, "rnd_a");

    // Switch to the no-preamble, 8-byte, no-timeout instance.
    set_ctrl(0, 1'b0, 1'b0, "a_off");
    set_ctrl(1, 1'b0, 1'b1, "b_on");
    wr(1, 10'h279, key[0], 1'b0, "b_6a");
    wr(1, 10'h279, key[1], 1'b0, "b_b5");
    wr(1, 10'h279, key[0], 1'b0, "b_6a_again");
    write_key(1, 1, 8, "b_key");
    pulse_rtw(1, "b_rtw");
    write_key(1, 0, 3, "b_part");
    repeat (500) @(posedge clk);
    #1 check_outputs(1, "b_no_timeout", 1'b0, 1'b0);
    write_key(1, 3, 8, "b_rest");
    pulse_rtw(1, "b_rtw2");
    random_writes(1, 60, "rnd_b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/isa_pnp_key_watcher.md
Name: isa_pnp_key_watcher

Overview:
Parametrised successor to the PnP initiation-key sniffer. It watches ISA I/O writes to the PnP address port for a configurable-length LFSR initiation key, with an optional spec-mandated 0x00,0x00 LFSR-reset preamble. It adds input synchronisation, an inter-byte timeout and an explicit return-to-Wait-for-Key path from the PnP controller. It sits between the raw ISA bus pins and isa_pnp_controller, and gates legacy versus PnP address decode.

Parameters:
ADDR_W, 10, width of compared I/O address (10 or 12)
KEY_PORT, 'h279, address-port value compared against isa_addr[ADDR_W-1:0]
KEY_LEN, 32, key length in bytes (2..255)
LFSR_SEED, 8'h6A, first key byte
REQUIRE_PREAMBLE, 1, 1 = two consecutive 0x00 writes must precede the seed; 0 = seed alone starts matching
TIMEOUT_CYCLES, 50000, clk cycles allowed between key writes; 0 = timeout disabled
SYNC_STAGES, 2, flops on isa_iow_n and isa_aen (≥2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
isa_addr  in  ADDR_W  SA bus
isa_data  in  8  SD[7:0]
isa_iow_n  in  1  raw IOW#, asynchronous
isa_aen  in  1  raw AEN (high = DMA cycle), asynchronous
sniffer_enable  in  1  0 = hold in legacy
force_legacy  in  1  override: abort and stay legacy
return_to_wfk  in  1  one-cycle pulse from PnP controller (Wait-for-Key command)
key_detected  out  1  one-cycle pulse on key completion
config_mode  out  1  PnP configuration mode active
legacy_mode  out  1  respond at legacy addresses
match_count  out  8  key bytes matched so far
key_abort  out  1  one-cycle pulse when a partial key is discarded by mismatch or timeout

Behaviour:
- Reset: state WAIT_KEY, LFSR=LFSR_SEED, sync flops=1 (iow) / 0 (aen), timer=0; key_detected=0, config_mode=0, legacy_mode=1, match_count=0, key_abort=0.
- Sync: isa_iow_n and isa_aen pass through SYNC_STAGES flops each. A write event occurs on the cycle the synchronised IOW# shows a 1→0 edge, synchronised AEN=0, and isa_addr==KEY_PORT. isa_addr and isa_data are sampled unsynchronised in that cycle.
- Latency: the raw IOW# fall is detected in cycle SYNC_STAGES+1. State, match_count and pulses update on the next clk edge.
- LFSR step: next = {cur[1]^cur[0], cur[7:1]}. Sequence is 6A, B5, DA, ED, F6, FB, 7D, BE, ...
- States:
  WAIT_KEY: 0x00 → PRE0 (if REQUIRE_PREAMBLE). Seed → MATCH with count=1 and LFSR stepped (if !REQUIRE_PREAMBLE). Other bytes ignored.
  PRE0: 0x00 → ARMED (LFSR←seed). Other byte → WAIT_KEY.
  ARMED: 0x00 → stay. Seed → MATCH with count=1 and LFSR stepped. Other byte → WAIT_KEY with key_abort.
  MATCH: byte==LFSR → count+1 and LFSR step; if the new count==KEY_LEN → CONFIG with key_detected pulse.
  MATCH mismatch: 0x00 → PRE0 (preamble mode). Seed → count=1 (non-preamble mode). Otherwise → WAIT_KEY. All mismatch paths pulse key_abort and clear count.
  CONFIG: key-port writes ignored. Leave to WAIT_KEY on return_to_wfk, force_legacy or !sniffer_enable.
- Precedence per cycle: force_legacy > !sniffer_enable > return_to_wfk > write event > timeout. The first three force WAIT_KEY, count=0 and LFSR=seed. They pulse key_abort only if the state was PRE0, ARMED or MATCH.
- Timeout: timer clears on every write event and whenever the state is WAIT_KEY or CONFIG. Otherwise it increments, saturating. When TIMEOUT_CYCLES≠0 and timer==TIMEOUT_CYCLES-1 → WAIT_KEY with key_abort.
- Outputs are registered. config_mode = (state==CONFIG). legacy_mode = !config_mode. A key completing while force_legacy is asserted is discarded.
- Reset mid-key returns to the reset values immediately (asynchronous).
- match_count is zero-extended. KEY_LEN ≤ 255 guarantees no wrap.

Test Plan:
- Preamble mode, sniffer_enable=1: write 00, 00, then the 32-byte key to 0x279 → key_detected pulses once after byte 32; config_mode=1, legacy_mode=0, match_count=32.
- Same sequence but byte 10 = 0x55 → key_abort pulse, match_count=0, state WAIT_KEY; a full retry with 00, 00 and key succeeds.
- Write 00, 00, 6A, B5, then idle TIMEOUT_CYCLES → key_abort at exactly TIMEOUT_CYCLES after the last write; a later B5 alone is ignored.
- Full key written with isa_aen=1, or to 0x27A → no state change, match_count stays 0.
- In CONFIG: pulse return_to_wfk → config_mode=0 and legacy_mode=1 the next cycle. Assert force_legacy during byte 20 → abort and no detection.
- REQUIRE_PREAMBLE=0, KEY_LEN=8: write 6A, B5, 6A, then 8 correct bytes → count restarts at 1 on the repeated 6A, and detection fires after the 8th correct byte.
